// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Latency: none (types and constants only).
// Backpressure: none; the divider's handshake is start/busy/done.
package div_pkg;

  // Default operand widths: dividend/quotient and divisor/remainder.
  localparam int DW_DEF = 16;
  localparam int VW_DEF = 8;

  // FSM state encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/div_seq_if.sv
// Request/result bundle between a divider client and div_seq.
// Latency: none (wiring only).
// Backpressure: start is only honoured while the divider is not busy.
interface div_seq_if
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
);

  logic          start;
  logic [DW-1:0] a;
  logic [VW-1:0] b;
  logic          busy;
  logic          done;
  logic [DW-1:0] q;
  logic [VW-1:0] r;
  logic          dz;

  // Client side: issues operands, observes status and results.
  modport master (
    output start, a, b,
    input  busy, done, q, r, dz
  );

  // Divider side.
  modport slave (
    input  start, a, b,
    output busy, done, q, r, dz
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract.
// Latency: purely combinational.
// Backpressure: none.
module div_step
  import div_pkg::*;
#(
  parameter int VW = VW_DEF
) (
  input  logic [VW:0]   i_rem,
  input  logic          i_quo_msb,
  input  logic [VW-1:0] i_div,
  output logic [VW:0]   o_rem,
  output logic          o_qbit
);

  // Shifted partial remainder carries one spare bit so the compare and
  // subtract can never overflow, whatever the incoming remainder holds.
  logic [VW+1:0] w_shift;
  logic [VW+1:0] w_div_ext;

  // Trial subtraction: keep the difference when the divisor fits.
  always_comb begin
    w_shift   = {i_rem, i_quo_msb};
    w_div_ext = (VW+2)'(i_div);
    o_qbit    = (w_shift >= w_div_ext);
    o_rem     = o_qbit ? (VW+1)'(w_shift - w_div_ext) : (VW+1)'(w_shift);
  end

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider, one quotient bit per clock (q = a / b, r = a % b).
// Latency: DW clocks from the accepting edge to done; 1 clock for divide-by-zero.
// Backpressure: start is sampled only in IDLE/DONE; starts during RUN are dropped.
module div_seq
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic    clk,
  input  logic    rst_n,
  div_seq_if.slave bus
);

  localparam int CW = $clog2(DW + 1);

  // FSM
  state_t r_state;
  state_t w_next;

  // Working registers for the iteration.
  logic [CW-1:0] r_cnt;
  logic [VW:0]   r_rem;
  logic [DW-1:0] r_quo;
  logic [VW-1:0] r_div;

  // Output registers.
  logic          r_busy;
  logic          r_done;
  logic          r_dz;
  logic [DW-1:0] r_q;
  logic [VW-1:0] r_r;

  // Decoded controls.
  logic          w_accept;
  logic          w_bz;
  logic          w_last;
  logic [VW:0]   w_rem_nxt;
  logic          w_qbit;
  logic [DW-1:0] w_quo_nxt;

  div_step #(.VW(VW)) u_step (
    .i_rem     (r_rem),
    .i_quo_msb (r_quo[DW-1]),
    .i_div     (r_div),
    .o_rem     (w_rem_nxt),
    .o_qbit    (w_qbit)
  );

  // The dividend drains out of the MSB while quotient bits enter the LSB.
  assign w_quo_nxt = {r_quo[DW-2:0], w_qbit};

  // State register; reset abandons any division in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: accept in IDLE/DONE, leave RUN after the final bit.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_bz     = (bus.b == '0);
    w_last   = (r_cnt == CW'(1));
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          // A zero divisor has a fixed answer, so skip the iteration.
          w_next   = w_bz ? S_DONE : S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture on accept, then one shift/subtract per RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
    end else if (w_accept && !w_bz) begin
      r_cnt <= CW'(DW);
      r_rem <= '0;
      r_quo <= bus.a;
      r_div <= bus.b;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt - CW'(1);
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
    end
  end

  // Results change only when entering DONE and are held otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q  <= '0;
      r_r  <= '0;
      r_dz <= 1'b0;
    end else if (w_accept && w_bz) begin
      r_q  <= '1;
      r_r  <= '0;
      r_dz <= 1'b1;
    end else if (r_state == S_RUN && w_last) begin
      r_q  <= w_quo_nxt;
      r_r  <= w_rem_nxt[VW-1:0];
      r_dz <= 1'b0;
    end
  end

  // Status flags registered from the next state so outputs never see inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next == S_RUN);
      r_done <= (w_next == S_DONE);
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.q    = r_q;
  assign bus.r    = r_r;
  assign bus.dz   = r_dz;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases plus random operand pairs.
// A cycle-level behavioural model (plain / and %) is compared every cycle.
// Directed cases additionally pin latency, busy length and literal results.
module tb_div_seq;
  import div_pkg::*;

  localparam int DW = 16;
  localparam int VW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  div_seq_if #(.DW(DW), .VW(VW)) bus ();

  div_seq #(.DW(DW), .VW(VW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit        m_busy, m_done, m_dz;
  bit [15:0] m_q, m_pq, m_a;
  bit [7:0]  m_r, m_pr, m_b;
  int        m_left;
  bit        chk_en = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_dz = 0; m_q = 0; m_r = 0; m_left = 0;
      chk_en = 1'b1;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 0; m_done = 1; m_q = m_pq; m_r = m_pr; m_dz = 0;
      end
    end else if (bus.start) begin
      m_a = bus.a;
      m_b = bus.b;
      if (bus.b == 8'd0) begin
        m_busy = 0; m_done = 1; m_q = 16'hFFFF; m_r = 0; m_dz = 1;
      end else begin
        m_pq = bus.a / {8'd0, bus.b};
        m_pr = 8'(bus.a % {8'd0, bus.b});
        m_left = DW; m_busy = 1; m_done = 0;
      end
    end else begin
      m_done = 0;
    end
  end

  // Compare process: every cycle once reset has been applied.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("dz",   32'(bus.dz),   32'(m_dz));
      chk("q",    32'(bus.q),    32'(m_q));
      chk("r",    32'(bus.r),    32'(m_r));
      if (bus.done === 1'b1 && !m_dz) begin
        chk("q*b+r==a", 32'(bus.q) * 32'(m_b) + 32'(bus.r), 32'(m_a));
        chk("r<b", 32'(bus.r < m_b), 32'd1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge with the DUT in IDLE or DONE. lat counts edges after
  // the accepting edge until done is visible; inj>0 pulses a spurious start
  // that many cycles into the run.
  task automatic op(input logic [15:0] ai, input logic [7:0] bi, input int elat,
                    input logic [15:0] eq, input logic [7:0] er, input logic edz,
                    input int inj, input string nm);
    int lat;
    int nb;
    bus.start = 1'b1; bus.a = ai; bus.b = bi;
    @(negedge clk);
    bus.start = 1'b0; bus.a = 16'($urandom); bus.b = 8'($urandom);
    lat = 0;
    nb  = int'(bus.busy);
    while (bus.done !== 1'b1 && lat < 40) begin
      if (lat == inj) begin
        bus.start = 1'b1; bus.a = 16'd9; bus.b = 8'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
      nb += int'(bus.busy);
    end
    bus.start = 1'b0;
    chk({nm, "_lat"},  32'(lat), 32'(elat));
    chk({nm, "_busy"}, 32'(nb),  32'(elat));
    chk({nm, "_q"},    32'(bus.q),  32'(eq));
    chk({nm, "_r"},    32'(bus.r),  32'(er));
    chk({nm, "_dz"},   32'(bus.dz), 32'(edz));
  endtask

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_q",    32'(bus.q),    0);
    chk("rst_r",    32'(bus.r),    0);
    chk("rst_dz",   32'(bus.dz),   0);
    rst_n = 1'b1;
    idle(2);

    op(16'd6, 8'd3, 16, 16'd2, 8'd0, 1'b0, -1, "d6_3");
    chk("model_q_6_3", 32'(m_q), 32'd2);
    idle(2);
    op(16'd1000, 8'd7, 16, 16'd142, 8'd6, 1'b0, -1, "d1000_7");
    chk("model_r_1000_7", 32'(m_r), 32'd6);
    idle(1);
    op(16'hFFFF, 8'hFF, 16, 16'h0101, 8'd0, 1'b0, -1, "dffff_ff");
    // Back-to-back: next start issued in the DONE cycle.
    op(16'd5, 8'd9, 16, 16'd0, 8'd5, 1'b0, -1, "d5_9");
    idle(2);

    op(16'd1234, 8'd0, 0, 16'hFFFF, 8'd0, 1'b1, -1, "dz1");
    // Second divide-by-zero right behind the first: done stays high.
    op(16'd7, 8'd0, 0, 16'hFFFF, 8'd0, 1'b1, -1, "dz2");
    idle(2);

    // Spurious start mid-run must not disturb the original result.
    op(16'd1000, 8'd7, 16, 16'd142, 8'd6, 1'b0, 5, "ignore");
    op(16'd100, 8'd10, 16, 16'd10, 8'd0, 1'b0, -1, "b2b_100_10");
    idle(2);

    // Reset in the middle of a run.
    bus.start = 1'b1; bus.a = 16'd1000; bus.b = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    idle(7);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_done", 32'(bus.done), 0);
    chk("midrst_q",    32'(bus.q),    0);
    chk("midrst_r",    32'(bus.r),    0);
    chk("midrst_dz",   32'(bus.dz),   0);
    idle(1);
    op(16'd100, 8'd10, 16, 16'd10, 8'd0, 1'b0, -1, "after_rst");
    idle(1);

    for (int i = 0; i < 2000; i++) begin
      logic [15:0] ra;
      logic [7:0]  rb;
      ra = 16'($urandom);
      rb = 8'($urandom_range(1, 255));
      op(ra, rb, 16, 16'(ra / {8'd0, rb}), 8'(ra % {8'd0, rb}), 1'b0, -1, "rand");
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #5000000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
